// File: rtl/adv_video_timing_if.sv
// rtl/adv_video_timing_if.sv - framebuffer read port and ADV7513-style video output bundle
interface adv_video_timing_if;
  logic [18:0] PIX_Address;
  logic        PIX_Read;
  logic [23:0] PIX_Data;
  logic        ADV_CLK;
  logic        ADV_DE;
  logic [23:0] ADV_D;
  logic        ADV_Hsync;
  logic        ADV_Vsync;
  logic        FRAME_START;

  modport master (
    output PIX_Address, PIX_Read, ADV_CLK, ADV_DE, ADV_D, ADV_Hsync, ADV_Vsync, FRAME_START,
    input  PIX_Data
  );

  modport slave (
    input  PIX_Address, PIX_Read, ADV_CLK, ADV_DE, ADV_D, ADV_Hsync, ADV_Vsync, FRAME_START,
    output PIX_Data
  );
endinterface

// File: rtl/adv_video_timing.sv
// rtl/adv_video_timing.sv - hot-plug gated VGA-style timing generator with framebuffer fetch
// Runs at half the system clock; counter -> read -> output pipeline is two pixel ticks deep.
module adv_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int HPD_DEB  = 1024
) (
  input  logic FPGA_CLK1_50,
  input  logic RST,
  input  logic ADV_HPD,
  adv_video_timing_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(HPD_DEB + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(HPD_DEB - 1);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, RUN} state_t;

  state_t        state_q, state_d;
  logic          hpd_meta_q, hpd_meta_d, hpd_sync_q, hpd_sync_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          pix_ce_q, pix_ce_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_cnt_q, addr_cnt_d;
  logic          s1_active_q, s1_active_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_first_q, s1_first_d;
  logic          pix_read_q, pix_read_d;
  logic [18:0]   pix_addr_q, pix_addr_d;
  logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [23:0]   dat_q, dat_d;
  logic          frame_start_q, frame_start_d, adv_clk_q, adv_clk_d;
  logic          active0, hs0, vs0, first0, run_ok;

  always_comb begin
    hpd_meta_d = ADV_HPD;
    hpd_sync_d = hpd_meta_q;
    state_d    = state_q;
    deb_d      = deb_q;
    case (state_q)
      IDLE: if (hpd_sync_q) begin
        state_d = DEBOUNCE;
        deb_d   = DW'(1);
      end
      // The IDLE clock that first sees HPD counts as debounce sample one.
      DEBOUNCE: if (!hpd_sync_q) begin
        state_d = IDLE;
        deb_d   = '0;
      end else if (deb_q >= DEB_LAST) begin
        state_d = RUN;
        deb_d   = '0;
      end else begin
        deb_d = deb_q + DW'(1);
      end
      RUN:     if (!hpd_sync_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active0 = (h_q < H_ACT) && (v_q < V_ACT);
    hs0     = (h_q >= HS_BEG) && (h_q <= HS_END);
    vs0     = (v_q >= VS_BEG) && (v_q <= VS_END);
    first0  = (h_q == '0) && (v_q == '0);
    run_ok  = (state_q == RUN) && hpd_sync_q;

    pix_ce_d      = pix_ce_q;
    h_d           = h_q;
    v_d           = v_q;
    addr_cnt_d    = addr_cnt_q;
    s1_active_d   = s1_active_q;
    s1_hs_d       = s1_hs_q;
    s1_vs_d       = s1_vs_q;
    s1_first_d    = s1_first_q;
    pix_addr_d    = pix_addr_q;
    de_d          = de_q;
    dat_d         = dat_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    pix_read_d    = 1'b0;
    frame_start_d = 1'b0;
    adv_clk_d     = 1'b0;

    // Any exit from RUN (including HPD loss) flushes the whole pipeline at once.
    if (!run_ok) begin
      pix_ce_d    = 1'b0;
      h_d         = '0;
      v_d         = '0;
      addr_cnt_d  = '0;
      s1_active_d = 1'b0;
      s1_hs_d     = 1'b0;
      s1_vs_d     = 1'b0;
      s1_first_d  = 1'b0;
      pix_addr_d  = '0;
      de_d        = 1'b0;
      dat_d       = '0;
      hsync_d     = SYNC_OFF;
      vsync_d     = SYNC_OFF;
    end else begin
      pix_ce_d  = ~pix_ce_q;
      adv_clk_d = ~pix_ce_q;
      if (pix_ce_q) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
        if ((h_q == H_LAST) && (v_q == V_LAST)) addr_cnt_d = '0;
        else if (active0)                       addr_cnt_d = addr_cnt_q + 19'd1;

        s1_active_d = active0;
        s1_hs_d     = hs0;
        s1_vs_d     = vs0;
        s1_first_d  = first0;
        pix_read_d  = active0;
        if (active0) pix_addr_d = addr_cnt_q;

        de_d          = s1_active_q;
        dat_d         = s1_active_q ? vif.PIX_Data : 24'd0;
        hsync_d       = s1_hs_q ^ SYNC_OFF;
        vsync_d       = s1_vs_q ^ SYNC_OFF;
        frame_start_d = s1_first_q;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      hpd_meta_q    <= 1'b0;
      hpd_sync_q    <= 1'b0;
      deb_q         <= '0;
      pix_ce_q      <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      addr_cnt_q    <= '0;
      s1_active_q   <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_first_q    <= 1'b0;
      pix_read_q    <= 1'b0;
      pix_addr_q    <= '0;
      de_q          <= 1'b0;
      dat_q         <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      frame_start_q <= 1'b0;
      adv_clk_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hpd_meta_q    <= hpd_meta_d;
      hpd_sync_q    <= hpd_sync_d;
      deb_q         <= deb_d;
      pix_ce_q      <= pix_ce_d;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_cnt_q    <= addr_cnt_d;
      s1_active_q   <= s1_active_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_first_q    <= s1_first_d;
      pix_read_q    <= pix_read_d;
      pix_addr_q    <= pix_addr_d;
      de_q          <= de_d;
      dat_q         <= dat_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      adv_clk_q     <= adv_clk_d;
    end
  end

  assign vif.PIX_Address = pix_addr_q;
  assign vif.PIX_Read    = pix_read_q;
  assign vif.ADV_CLK     = adv_clk_q;
  assign vif.ADV_DE      = de_q;
  assign vif.ADV_D       = dat_q;
  assign vif.ADV_Hsync   = hsync_q;
  assign vif.ADV_Vsync   = vsync_q;
  assign vif.FRAME_START = frame_start_q;
endmodule

// File: tb/tb_adv_video_timing.sv
// tb/tb_adv_video_timing.sv - scoreboard and HPD vector-table bench for adv_video_timing
module tb_adv_video_timing;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int DEB = 16;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  typedef struct packed {
    logic        de;
    logic [23:0] d;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        rd;
    logic        aclk;
    logic        chk_addr;
    logic [18:0] addr;
  } exp_t;

  typedef struct {
    int hi1;
    int lo;
    int hi2;
    bit exp_clk;
    bit exp_de;
  } hpd_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hpd = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_m = 0;
  bit   clk_seen = 1'b0;
  bit   de_seen = 1'b0;
  exp_t exp_q[$];

  adv_video_timing_if bus ();

  adv_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .HPD_DEB(DEB)
  ) dut (
    .FPGA_CLK1_50(clk),
    .RST         (rst),
    .ADV_HPD     (hpd),
    .vif         (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer: data = address, valid only in the clock after a read strobe.
  always @(posedge clk) bus.PIX_Data <= bus.PIX_Read ? {5'd0, bus.PIX_Address} : 24'hBADBAD;

  function automatic exp_t idle_rec();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.chk_addr = 1'b1;
    return e;
  endfunction

  // n = clock edges since the edge that entered RUN.
  function automatic exp_t model(int n);
    exp_t e;
    int j, p, h, v;
    e = idle_rec();
    if (n < 0) return e;
    e.aclk = (n >= 1) && (n % 2 == 1);
    if (n >= 2) e.chk_addr = 1'b0;
    if (n >= 2 && n % 2 == 0) begin
      j = n / 2 - 1;
      h = j % HT;
      v = (j / HT) % VT;
      if (h < HA && v < VA) begin
        e.rd = 1'b1;
        e.chk_addr = 1'b1;
        e.addr = 19'(v * HA + h);
      end
    end
    if (n >= 4) begin
      p = (n - 4) / 2;
      h = p % HT;
      v = (p / HT) % VT;
      e.de = (h < HA) && (v < VA);
      e.d  = e.de ? 24'(v * HA + h) : 24'd0;
      e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
      e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
      e.fs = (n % 2 == 0) && (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic compare_rec(input string name, input exp_t e);
    logic ok;
    ok = (bus.ADV_DE === e.de) && (bus.ADV_D === e.d) && (bus.ADV_Hsync === e.hs) &&
         (bus.ADV_Vsync === e.vs) && (bus.FRAME_START === e.fs) && (bus.PIX_Read === e.rd) &&
         (bus.ADV_CLK === e.aclk) && (!e.chk_addr || (bus.PIX_Address === e.addr));
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got de=%b d=%h hs=%b vs=%b fs=%b rd=%b clk=%b addr=%0d ; exp de=%b d=%h hs=%b vs=%b fs=%b rd=%b clk=%b addr=%0d(chk=%b)",
               name, bus.ADV_DE, bus.ADV_D, bus.ADV_Hsync, bus.ADV_Vsync, bus.FRAME_START,
               bus.PIX_Read, bus.ADV_CLK, bus.PIX_Address,
               e.de, e.d, e.hs, e.vs, e.fs, e.rd, e.aclk, e.addr, e.chk_addr);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) compare_rec($sformatf("video m=%0d", cur_m), exp_q.pop_front());
  end

  always @(negedge clk) begin
    if (bus.ADV_CLK === 1'b1) clk_seen = 1'b1;
    if (bus.ADV_DE === 1'b1) de_seen = 1'b1;
  end

  // Clock m=1 is the first edge at which the synchroniser can see HPD high.
  task automatic run_seq(input int total, input int drop_at);
    for (int m = 1; m <= total; m++) begin
      @(posedge clk);
      #1;
      cur_m = m;
      if (drop_at >= 0 && m >= drop_at + 3) exp_q.push_back(idle_rec());
      else exp_q.push_back(model(m - (2 + DEB)));
      if (m == drop_at) hpd = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  hpd_vec_t vt[8];

  initial begin
    vt[0] = '{5,       0, 0,       1'b0, 1'b0};
    vt[1] = '{DEB / 2, 0, 0,       1'b0, 1'b0};
    vt[2] = '{DEB,     0, 0,       1'b0, 1'b0};
    vt[3] = '{DEB + 1, 0, 0,       1'b1, 1'b0};
    vt[4] = '{DEB + 3, 0, 0,       1'b1, 1'b0};
    vt[5] = '{DEB + 4, 0, 0,       1'b1, 1'b1};
    vt[6] = '{10,      1, DEB - 2, 1'b0, 1'b0};
    vt[7] = '{DEB - 1, 1, DEB + 4, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    compare_rec("reset_state", idle_rec());
    @(negedge clk);
    rst = 1'b0;

    // Two full frames, then HPD loss mid-frame at h=5,v=2 of the third.
    @(posedge clk);
    #1;
    hpd = 1'b1;
    run_seq(2 + DEB + 2 * (2 * HT * VT + 2 * HT + 5) + 20, 2 + DEB + 2 * (2 * HT * VT + 2 * HT + 5));

    // Re-plug: fresh debounce, addresses restart at 0; stop mid-line 1.
    @(posedge clk);
    #1;
    hpd = 1'b1;
    run_seq(2 + DEB + 4 + 2 * (HT + 4), -1);

    // Asynchronous reset between clock edges while video is active.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compare_rec("rst_async", idle_rec());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_seq(2 + DEB + 4 + 2 * HT + 6, -1);

    for (int i = 0; i < 8; i++) begin
      rst = 1'b1;
      hpd = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clk_seen = 1'b0;
      de_seen = 1'b0;
      @(posedge clk);
      #1;
      hpd = 1'b1;
      repeat (vt[i].hi1) @(posedge clk);
      #1;
      hpd = 1'b0;
      if (vt[i].lo > 0) begin
        repeat (vt[i].lo) @(posedge clk);
        #1;
        hpd = 1'b1;
        repeat (vt[i].hi2) @(posedge clk);
        #1;
        hpd = 1'b0;
      end
      repeat (20) @(posedge clk);
      #1;
      check_int($sformatf("hpd_vec%0d clk_seen", i), int'(clk_seen), int'(vt[i].exp_clk));
      check_int($sformatf("hpd_vec%0d de_seen", i), int'(de_seen), int'(vt[i].exp_de));
      compare_rec($sformatf("hpd_vec%0d idle_after", i), idle_rec());
    end

    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
